// File: rtl/primer20k_ahb_mem_arb.sv
// Two-port AHB-Lite slave sharing one single-port synchronous BRAM between the
// SCR1 imem (read-only) and dmem (read/write) buses, with round-robin arbitration.
module primer20k_ahb_mem_arb #(
    parameter int          MEM_AW    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        imem_htrans,
    input  logic [31:0]       imem_haddr,
    input  logic [2:0]        imem_hsize,
    output logic              imem_hready,
    output logic [31:0]       imem_hrdata,
    output logic              imem_hresp,
    input  logic [1:0]        dmem_htrans,
    input  logic [31:0]       dmem_haddr,
    input  logic [2:0]        dmem_hsize,
    input  logic              dmem_hwrite,
    input  logic [31:0]       dmem_hwdata,
    output logic              dmem_hready,
    output logic [31:0]       dmem_hrdata,
    output logic              dmem_hresp,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [3:0]        imem_dbg_o,
    output logic [3:0]        dmem_dbg_o
);

    localparam int HI = MEM_AW + 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PEND  = 3'd1,
        ST_RDATA = 3'd2,
        ST_ERR1  = 3'd3,
        ST_ERR2  = 3'd4
    } port_state_e;

    // Index 0 is imem, index 1 is dmem throughout.
    port_state_e                st_q [2];
    port_state_e                st_d [2];
    logic [1:0][MEM_AW-1:0]     addr_q, addr_d;
    logic [1:0][3:0]            be_q, be_d;
    logic [1:0]                 wr_q, wr_d;
    logic [1:0]                 err_q, err_d;
    logic                       last_grant_q, last_grant_d;

    logic [1:0][31:0]           haddr;
    logic [1:0][2:0]            hsize;
    logic [1:0]                 req, hwrite, pend, gnt, hready, accept;

    assign haddr  = {dmem_haddr, imem_haddr};
    assign hsize  = {dmem_hsize, imem_hsize};
    assign req    = {dmem_htrans[1], imem_htrans[1]};
    assign hwrite = {dmem_hwrite, 1'b0};

    function automatic logic req_err(input logic [31:0] a, input logic [2:0] s);
        logic miss;
        miss = (a[31:HI] != BASE_ADDR[31:HI]);
        return miss || (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] a, input logic [2:0] s);
        case (s)
            3'd0:    return 4'b0001 << a;
            3'd1:    return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    // Round-robin: on contention the port that was not granted last wins.
    always_comb begin
        for (int p = 0; p < 2; p++) pend[p] = (st_q[p] == ST_PEND);
        gnt = pend;
        if (pend == 2'b11) gnt = last_grant_q ? 2'b01 : 2'b10;
        last_grant_d = last_grant_q;
        if (gnt[1])      last_grant_d = 1'b1;
        else if (gnt[0]) last_grant_d = 1'b0;
    end

    // hready doubles as the address-phase ready: an address is taken whenever
    // htrans[1] and this port's own hready are both high in the same cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hready[p] = 1'b1;
            case (st_q[p])
                ST_PEND: hready[p] = gnt[p] & wr_q[p];
                ST_ERR1: hready[p] = 1'b0;
                default: hready[p] = 1'b1;
            endcase
            accept[p] = req[p] & hready[p];
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            st_d[p]   = st_q[p];
            addr_d[p] = addr_q[p];
            be_d[p]   = be_q[p];
            wr_d[p]   = wr_q[p];
            err_d[p]  = err_q[p];
            case (st_q[p])
                ST_PEND:  if (gnt[p]) st_d[p] = wr_q[p] ? ST_IDLE : ST_RDATA;
                ST_ERR1:  st_d[p] = ST_ERR2;
                default:  st_d[p] = ST_IDLE;
            endcase
            if (accept[p]) begin
                err_d[p]  = req_err(haddr[p], hsize[p]);
                addr_d[p] = haddr[p][HI-1:2];
                be_d[p]   = byte_en(haddr[p][1:0], hsize[p]);
                wr_d[p]   = hwrite[p];
                st_d[p]   = err_d[p] ? ST_ERR1 : ST_PEND;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) st_q[p] <= ST_IDLE;
            addr_q       <= '0;
            be_q         <= '0;
            wr_q         <= '0;
            err_q        <= '0;
            last_grant_q <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) st_q[p] <= st_d[p];
            addr_q       <= addr_d;
            be_q         <= be_d;
            wr_q         <= wr_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign mem_en    = |gnt;
    assign mem_addr  = gnt[1] ? addr_q[1] : (gnt[0] ? addr_q[0] : '0);
    assign mem_we    = (gnt[1] & wr_q[1]) ? be_q[1] : 4'b0000;
    assign mem_wdata = dmem_hwdata;

    assign imem_hready = hready[0];
    assign dmem_hready = hready[1];
    assign imem_hresp  = (st_q[0] == ST_ERR1) || (st_q[0] == ST_ERR2);
    assign dmem_hresp  = (st_q[1] == ST_ERR1) || (st_q[1] == ST_ERR2);
    assign imem_hrdata = (st_q[0] == ST_RDATA) ? mem_rdata : 32'h0;
    assign dmem_hrdata = (st_q[1] == ST_RDATA) ? mem_rdata : 32'h0;

    assign imem_dbg_o = {err_q[0], st_q[0]};
    assign dmem_dbg_o = {err_q[1], st_q[1]};

    logic unused_bits;
    assign unused_bits = ^{imem_htrans[0], dmem_htrans[0], be_q[0]};

endmodule

// File: tb/tb_primer20k_ahb_mem_arb.sv
// Bench for primer20k_ahb_mem_arb: AHB master drivers, a BRAM model, and
// scoreboard monitors for both ports and the RAM strobe.
module tb_primer20k_ahb_mem_arb;

    localparam int MEM_AW = 14;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        imem_htrans = 2'b00;
    logic [31:0]       imem_haddr = '0;
    logic [2:0]        imem_hsize = 3'd2;
    logic              imem_hready;
    logic [31:0]       imem_hrdata;
    logic              imem_hresp;
    logic [1:0]        dmem_htrans = 2'b00;
    logic [31:0]       dmem_haddr = '0;
    logic [2:0]        dmem_hsize = 3'd2;
    logic              dmem_hwrite = 1'b0;
    logic [31:0]       dmem_hwdata = 32'hCAFE_F00D;
    logic              dmem_hready;
    logic [31:0]       dmem_hrdata;
    logic              dmem_hresp;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic [3:0]        imem_dbg, dmem_dbg;

    always #5 clk = ~clk;

    primer20k_ahb_mem_arb #(.MEM_AW(MEM_AW), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_htrans(imem_htrans), .imem_haddr(imem_haddr), .imem_hsize(imem_hsize),
        .imem_hready(imem_hready), .imem_hrdata(imem_hrdata), .imem_hresp(imem_hresp),
        .dmem_htrans(dmem_htrans), .dmem_haddr(dmem_haddr), .dmem_hsize(dmem_hsize),
        .dmem_hwrite(dmem_hwrite), .dmem_hwdata(dmem_hwdata),
        .dmem_hready(dmem_hready), .dmem_hrdata(dmem_hrdata), .dmem_hresp(dmem_hresp),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .imem_dbg_o(imem_dbg), .dmem_dbg_o(dmem_dbg)
    );

    // Synchronous BRAM model; the first edge loads the preset contents.
    logic [31:0] ram [0:(1<<MEM_AW)-1];
    bit          ram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < (1 << MEM_AW); i++) ram[i] <= 32'h0;
            ram[14'h040] <= 32'hDEAD_BEEF;
            ram[14'h080] <= 32'h1122_3344;
            ram[14'h081] <= 32'h5566_7788;
            ram[14'h0C0] <= 32'h0BAD_F00D;
            ram[14'h3FFF] <= 32'h5A5A_1234;
            for (int k = 0; k < 4; k++) begin
                ram[14'h100 + k] <= 32'hA000_0000 + k;
                ram[14'h200 + k] <= 32'hB000_0000 + k;
            end
            ram_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we == 4'b0000) mem_rdata <= ram[mem_addr];
            else for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    // Port entry: {hresp, hrdata, wait states}; RAM entry: {we, addr, wdata-or-0}.
    logic [40:0] exp_q_i[$];
    logic [40:0] exp_q_d[$];
    logic [49:0] exp_q_m[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s got=no_response exp=response", name);
    endtask

    function automatic logic [40:0] pexp(input logic resp, input logic [31:0] d, input int w);
        return {resp, d, 8'(w)};
    endfunction

    function automatic logic [49:0] mexp(input logic [3:0] we, input logic [13:0] a, input logic [31:0] d);
        return {we, a, d};
    endfunction

    bit act [2];
    int ws [2];

    task automatic mon_port(input int p, input logic [1:0] htrans, input logic hready,
                            input logic hresp, input logic [31:0] hrdata);
        logic [40:0] e;
        int          sz;
        string       pn;
        pn = (p == 0) ? "imem" : "dmem";
        sz = (p == 0) ? exp_q_i.size() : exp_q_d.size();
        if (act[p]) begin
            if (!hready) begin
                ws[p]++;
                if (sz == 0) fail_now({pn, "_unexpected_stall"});
                else begin
                    e = (p == 0) ? exp_q_i[0] : exp_q_d[0];
                    check({pn, "_stall_hresp"}, 64'(hresp), 64'(e[40]));
                end
            end else begin
                if (sz == 0) fail_now({pn, "_unexpected_done"});
                else begin
                    e = (p == 0) ? exp_q_i.pop_front() : exp_q_d.pop_front();
                    check({pn, "_done_resp_data_waits"}, 64'({hresp, hrdata, 8'(ws[p])}), 64'(e));
                end
                ws[p]  = 0;
                act[p] = 1'b0;
            end
        end
        if (hready) act[p] = htrans[1];
    endtask

    task automatic mon_mem();
        logic [49:0] e;
        if (mem_en) begin
            if (exp_q_m.size() == 0) fail_now("mem_unexpected_access");
            else begin
                e = exp_q_m.pop_front();
                check("mem_access", 64'({mem_we, mem_addr, (mem_we != 4'b0) ? mem_wdata : 32'h0}), 64'(e));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act = '{1'b0, 1'b0};
                ws  = '{0, 0};
            end else begin
                mon_port(0, imem_htrans, imem_hready, imem_hresp, imem_hrdata);
                mon_port(1, dmem_htrans, dmem_hready, dmem_hresp, dmem_hrdata);
                mon_mem();
            end
        end
    end

    task automatic imem_read(input logic [31:0] addr, input logic [2:0] size);
        int n;
        @(posedge clk); #1;
        imem_htrans = 2'b10; imem_haddr = addr; imem_hsize = size;
        n = 0; @(negedge clk);
        while (!imem_hready && n < 50) begin n++; @(negedge clk); end
        if (n >= 50) fail_now("imem_accept_timeout");
        @(posedge clk); #1;
        imem_htrans = 2'b00;
        n = 0; @(negedge clk);
        while (!imem_hready && n < 50) begin n++; @(negedge clk); end
        if (n >= 50) fail_now("imem_done_timeout");
    endtask

    task automatic dmem_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata);
        int n;
        @(posedge clk); #1;
        dmem_htrans = 2'b10; dmem_haddr = addr; dmem_hsize = size; dmem_hwrite = wr;
        n = 0; @(negedge clk);
        while (!dmem_hready && n < 50) begin n++; @(negedge clk); end
        if (n >= 50) fail_now("dmem_accept_timeout");
        @(posedge clk); #1;
        dmem_htrans = 2'b00; dmem_hwrite = 1'b0; dmem_hwdata = wdata;
        n = 0; @(negedge clk);
        while (!dmem_hready && n < 50) begin n++; @(negedge clk); end
        if (n >= 50) fail_now("dmem_done_timeout");
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_imem_hready"}, 64'(imem_hready), 64'd1);
        check({tag, "_dmem_hready"}, 64'(dmem_hready), 64'd1);
        check({tag, "_hresp"}, 64'({imem_hresp, dmem_hresp}), 64'd0);
        check({tag, "_hrdata"}, 64'({imem_hrdata, dmem_hrdata}), 64'd0);
        check({tag, "_mem_en_we"}, 64'({mem_en, mem_we}), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(dmem_hwdata));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single imem read: one wait state.
        exp_q_m.push_back(mexp(4'b0000, 14'h040, 32'h0));
        exp_q_i.push_back(pexp(1'b0, 32'hDEAD_BEEF, 1));
        imem_read(32'h0000_0100, 3'd2);

        // Four contended rounds; last grant was imem, so dmem wins each round.
        for (int k = 0; k < 4; k++) begin
            exp_q_m.push_back(mexp(4'b0000, 14'(14'h200 + k), 32'h0));
            exp_q_m.push_back(mexp(4'b0000, 14'(14'h100 + k), 32'h0));
            exp_q_d.push_back(pexp(1'b0, 32'hB000_0000 + k, 1));
            exp_q_i.push_back(pexp(1'b0, 32'hA000_0000 + k, 2));
            fork
                imem_read(32'h400 + 4 * k, 3'd2);
                dmem_xfer(1'b0, 32'h800 + 4 * k, 3'd2, 32'h0);
            join
        end

        // Byte write, zero wait states.
        exp_q_m.push_back(mexp(4'b1000, 14'h080, 32'hAB00_0000));
        exp_q_d.push_back(pexp(1'b0, 32'h0, 0));
        dmem_xfer(1'b1, 32'h203, 3'd0, 32'hAB00_0000);

        // Contention after a dmem grant: imem must win this time.
        exp_q_m.push_back(mexp(4'b0000, 14'h040, 32'h0));
        exp_q_m.push_back(mexp(4'b0000, 14'h080, 32'h0));
        exp_q_i.push_back(pexp(1'b0, 32'hDEAD_BEEF, 1));
        exp_q_d.push_back(pexp(1'b0, 32'hAB22_3344, 2));
        fork
            imem_read(32'h100, 3'd2);
            dmem_xfer(1'b0, 32'h200, 3'd2, 32'h0);
        join

        // Halfword write to upper half, then halfword reads and top-of-range word.
        exp_q_m.push_back(mexp(4'b1100, 14'h081, 32'hBEEF_0000));
        exp_q_d.push_back(pexp(1'b0, 32'h0, 0));
        dmem_xfer(1'b1, 32'h206, 3'd1, 32'hBEEF_0000);
        exp_q_m.push_back(mexp(4'b0000, 14'h081, 32'h0));
        exp_q_d.push_back(pexp(1'b0, 32'hBEEF_7788, 1));
        dmem_xfer(1'b0, 32'h206, 3'd1, 32'h0);
        exp_q_m.push_back(mexp(4'b0000, 14'h040, 32'h0));
        exp_q_i.push_back(pexp(1'b0, 32'hDEAD_BEEF, 1));
        imem_read(32'h102, 3'd1);
        exp_q_m.push_back(mexp(4'b0000, 14'h3FFF, 32'h0));
        exp_q_d.push_back(pexp(1'b0, 32'h5A5A_1234, 1));
        dmem_xfer(1'b0, 32'h0000_FFFC, 3'd2, 32'h0);

        // Error responses: out of range, misaligned, bad size; RAM untouched.
        exp_q_d.push_back(pexp(1'b1, 32'h0, 1));
        dmem_xfer(1'b0, 32'h0001_0000, 3'd2, 32'h0);
        exp_q_d.push_back(pexp(1'b1, 32'h0, 1));
        dmem_xfer(1'b0, 32'h0000_0002, 3'd2, 32'h0);
        exp_q_d.push_back(pexp(1'b1, 32'h0, 1));
        dmem_xfer(1'b1, 32'h0000_0203, 3'd1, 32'hFFFF_FFFF);
        exp_q_i.push_back(pexp(1'b1, 32'h0, 1));
        imem_read(32'h101, 3'd1);
        exp_q_i.push_back(pexp(1'b1, 32'h0, 1));
        imem_read(32'h100, 3'd3);

        // Reset while a dmem write waits in PEND behind an imem grant.
        @(posedge clk); #1;
        imem_htrans = 2'b10; imem_haddr = 32'h100; imem_hsize = 3'd2;
        dmem_htrans = 2'b10; dmem_haddr = 32'h300; dmem_hsize = 3'd2; dmem_hwrite = 1'b1;
        @(posedge clk); #1;
        imem_htrans = 2'b00; dmem_htrans = 2'b00; dmem_hwrite = 1'b0;
        dmem_hwdata = 32'h1234_5678;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_mem_en_we", 64'({mem_en, mem_we}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("in_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        exp_q_m.push_back(mexp(4'b0000, 14'h0C0, 32'h0));
        exp_q_d.push_back(pexp(1'b0, 32'h0BAD_F00D, 1));
        dmem_xfer(1'b0, 32'h300, 3'd2, 32'h0);
        exp_q_m.push_back(mexp(4'b0000, 14'h040, 32'h0));
        exp_q_i.push_back(pexp(1'b0, 32'hDEAD_BEEF, 1));
        imem_read(32'h100, 3'd2);

        repeat (4) @(negedge clk);
        check("imem_queue_drained", 64'(exp_q_i.size()), 64'd0);
        check("dmem_queue_drained", 64'(exp_q_d.size()), 64'd0);
        check("mem_queue_drained", 64'(exp_q_m.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
